// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router ingress path.
// Optional payload-length checking is enabled by defining ROUTER_LEN_CHECK_EN.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int WIDTH     = 8;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Header byte layout: [7:2] payload length, [1:0] destination
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;
  localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

  typedef enum logic [2:0] {
    ST_DECODE,
    ST_WAIT_EMPTY,
    ST_LOAD_FIRST,
    ST_LOAD_DATA,
    ST_FULL_WAIT,
    ST_FLUSH,
    ST_CHECK,
    ST_DROP
  } state_t;

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity of a packet, latched parity byte and registered check result.
// With ROUTER_LEN_CHECK_EN defined, also compares the payload byte count to the header length.
module router_parity_chk
  import router_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             hdr_load,
  input  logic             pay_load,
  input  logic             par_load,
  input  logic             check,
  input  logic [WIDTH-1:0] data_in,
  output logic             err,
  output logic             parity_done
`ifdef ROUTER_LEN_CHECK_EN
  ,
  output logic             len_err
`endif
);

  logic [WIDTH-1:0] int_parity;
  logic [WIDTH-1:0] pkt_parity;

  always_ff @(posedge clock) begin
    if (reset) begin
      int_parity  <= '0;
      pkt_parity  <= '0;
      err         <= 1'b0;
      parity_done <= 1'b0;
    end else begin
      parity_done <= check;
      if (check)
        err <= (int_parity != pkt_parity);
      if (hdr_load)
        int_parity <= data_in;
      else if (pay_load)
        int_parity <= int_parity ^ data_in;
      if (par_load)
        pkt_parity <= data_in;
    end
  end

`ifdef ROUTER_LEN_CHECK_EN
  logic [LEN_W-1:0] pay_cnt;
  logic [LEN_W-1:0] hdr_len;

  always_ff @(posedge clock) begin
    if (reset) begin
      pay_cnt <= '0;
      hdr_len <= '0;
      len_err <= 1'b0;
    end else begin
      if (hdr_load) begin
        pay_cnt <= '0;
        hdr_len <= data_in[LEN_MSB:LEN_LSB];
      end else if (pay_load) begin
        pay_cnt <= pay_cnt + 1'b1;
      end
      if (check)
        len_err <= (pay_cnt != hdr_len);
    end
  end
`endif

endmodule

// File: rtl/router_ingress_ctrl.sv
// Ingress controller of the 1x3 router: header decode, FIFO steering, backpressure, parity check.
// Define ROUTER_LEN_CHECK_EN to add the len_err output (payload length check).
module router_ingress_ctrl
  import router_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic [WIDTH-1:0]     data_out,
  output logic                 err,
  output logic                 parity_done
`ifdef ROUTER_LEN_CHECK_EN
  ,
  output logic                 len_err
`endif
);

  state_t         state, state_nxt;
  logic           pend;
  logic [1:0]     dest;

  logic [1:0]     hdr_addr;
  logic [NUM_PORTS:0] full_ext, empty_ext, srst_ext;
  logic           dest_full;
  logic           abort;
  logic           wr_state;
  logic           wr;
  logic           consume;
  logic           hdr_load;
  logic           pay_load;
  logic           par_load;
  logic           check;

  // Padding the per-port flags lets the invalid address index safely
  assign full_ext  = {1'b0, fifo_full};
  assign empty_ext = {1'b0, fifo_empty};
  assign srst_ext  = {1'b0, soft_reset};

  always_comb begin
    hdr_addr  = data_in[ADDR_MSB:ADDR_LSB];
    dest_full = full_ext[dest];
    abort     = srst_ext[dest] && (state != ST_DECODE) && (state != ST_DROP);
    wr_state  = (state == ST_LOAD_DATA) || (state == ST_FULL_WAIT) || (state == ST_FLUSH);
    wr        = pend && !dest_full && wr_state && !abort;

    write_enb = '0;
    if (wr)
      write_enb[dest] = 1'b1;

    busy = 1'b1;
    case (state)
      ST_DECODE,
      ST_DROP:      busy = 1'b0;
      ST_LOAD_DATA: busy = pend && dest_full;
      default:      busy = 1'b1;
    endcase

    lfd_state = (state == ST_LOAD_FIRST);

    consume = 1'b0;
    if (!busy) begin
      if (state == ST_DECODE)
        consume = pkt_valid;
      else if ((state == ST_LOAD_DATA) || (state == ST_DROP))
        consume = 1'b1;
    end

    hdr_load = (state == ST_DECODE) && pkt_valid && (hdr_addr != ADDR_INVALID);
    pay_load = consume && (state == ST_LOAD_DATA) && pkt_valid;
    par_load = consume && (state == ST_LOAD_DATA) && !pkt_valid;
    check    = (state == ST_CHECK) && !abort;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_DROP;
    end else begin
      case (state)
        ST_DECODE: begin
          if (pkt_valid) begin
            if (hdr_addr == ADDR_INVALID)
              state_nxt = ST_DROP;
            else if (!empty_ext[hdr_addr])
              state_nxt = ST_WAIT_EMPTY;
            else
              state_nxt = ST_LOAD_FIRST;
          end
        end
        ST_WAIT_EMPTY: if (empty_ext[dest]) state_nxt = ST_LOAD_FIRST;
        ST_LOAD_FIRST: state_nxt = ST_LOAD_DATA;
        ST_LOAD_DATA: begin
          if (busy)
            state_nxt = ST_FULL_WAIT;
          else if (!pkt_valid)
            state_nxt = ST_FLUSH;
        end
        ST_FULL_WAIT:  if (wr) state_nxt = ST_LOAD_DATA;
        ST_FLUSH:      if (wr) state_nxt = ST_CHECK;
        ST_CHECK:      state_nxt = ST_DECODE;
        ST_DROP:       if (!pkt_valid) state_nxt = ST_DECODE;
        default:       state_nxt = ST_DECODE;
      endcase
    end
  end

  // Pending byte register: a fresh byte always wins over the write that drains the old one
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_DECODE;
      data_out <= '0;
      pend     <= 1'b0;
      dest     <= '0;
    end else begin
      state <= state_nxt;
      if (hdr_load)
        dest <= hdr_addr;
      if (consume)
        data_out <= data_in;
      if (abort)
        pend <= 1'b0;
      else if (consume)
        pend <= 1'b1;
      else if (wr)
        pend <= 1'b0;
    end
  end

  router_parity_chk u_parity (
    .clock       (clock),
    .reset       (reset),
    .hdr_load    (hdr_load),
    .pay_load    (pay_load),
    .par_load    (par_load),
    .check       (check),
    .data_in     (data_in),
    .err         (err),
    .parity_done (parity_done)
`ifdef ROUTER_LEN_CHECK_EN
    ,
    .len_err     (len_err)
`endif
  );

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// Directed bench for router_ingress_ctrl: nominal, parity error, abort, reset, backpressure,
// busy destination, invalid address and zero-length packets.
module tb_router_ingress_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] fifo_full = 3'b000;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] soft_reset = 3'b000;
  logic       busy;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic [7:0] data_out;
  logic       err;
  logic       parity_done;
`ifdef ROUTER_LEN_CHECK_EN
  logic       len_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  router_ingress_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .soft_reset  (soft_reset),
    .busy        (busy),
    .write_enb   (write_enb),
    .lfd_state   (lfd_state),
    .data_out    (data_out),
    .err         (err),
    .parity_done (parity_done)
`ifdef ROUTER_LEN_CHECK_EN
    ,
    .len_err     (len_err)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then drive the byte for the new cycle and let it settle.
  task automatic cyc(input logic pv, input logic [7:0] d);
    @(posedge clock);
    #2;
    pkt_valid = pv;
    data_in   = d;
    #1;
  endtask

  // Destination-1 packet: header 0D, payload 11 22 33, caller-chosen parity byte.
  task automatic pkt_d1(input logic [7:0] par, input logic exp_err);
    cyc(1'b1, 8'h0D); chk("nom_hdr_busy", busy, 8'd0);
    cyc(1'b1, 8'h11); chk("nom_lfd", lfd_state, 8'd1); chk("nom_lfd_we", write_enb, 8'd0);
                      chk("nom_lfd_busy", busy, 8'd1);
    cyc(1'b1, 8'h11); chk("nom_we_hdr", write_enb, 8'h02); chk("nom_do_hdr", data_out, 8'h0D);
                      chk("nom_lfd_off", lfd_state, 8'd0);
    cyc(1'b1, 8'h22); chk("nom_we_p1", write_enb, 8'h02); chk("nom_do_p1", data_out, 8'h11);
    cyc(1'b1, 8'h33); chk("nom_we_p2", write_enb, 8'h02); chk("nom_do_p2", data_out, 8'h22);
    cyc(1'b0, par);   chk("nom_we_p3", write_enb, 8'h02); chk("nom_do_p3", data_out, 8'h33);
    cyc(1'b0, 8'h00); chk("nom_we_par", write_enb, 8'h02); chk("nom_do_par", data_out, par);
                      chk("nom_flush_busy", busy, 8'd1);
    cyc(1'b0, 8'h00); chk("nom_chk_we", write_enb, 8'd0); chk("nom_chk_busy", busy, 8'd1);
                      chk("nom_chk_pd", parity_done, 8'd0);
    cyc(1'b0, 8'h00); chk("nom_pd", parity_done, 8'd1); chk("nom_err", err, {7'd0, exp_err});
                      chk("nom_dec_busy", busy, 8'd0);
    cyc(1'b0, 8'h00); chk("nom_pd_off", parity_done, 8'd0); chk("nom_err_hold", err, {7'd0, exp_err});
  endtask

  initial begin
    // Reset
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 8'd0);
    chk("rst_we", write_enb, 8'd0);
    chk("rst_lfd", lfd_state, 8'd0);
    chk("rst_do", data_out, 8'd0);
    chk("rst_err", err, 8'd0);
    chk("rst_pd", parity_done, 8'd0);

    // Nominal and parity-error packets
    pkt_d1(8'h0D, 1'b0);
    pkt_d1(8'h0C, 1'b1);

    // Abort on port 0 mid-payload
    cyc(1'b1, 8'h0C); chk("ab_hdr_busy", busy, 8'd0);
    cyc(1'b1, 8'h01); chk("ab_lfd", lfd_state, 8'd1);
    cyc(1'b1, 8'h01); chk("ab_we_hdr", write_enb, 8'h01); chk("ab_do_hdr", data_out, 8'h0C);
    cyc(1'b1, 8'h02); chk("ab_we_p1", write_enb, 8'h01); chk("ab_do_p1", data_out, 8'h01);
    cyc(1'b1, 8'h03);
    soft_reset = 3'b001;
    #1;
    chk("ab_we_cut", write_enb, 8'd0); chk("ab_busy", busy, 8'd0);
    cyc(1'b0, 8'hFF);
    soft_reset = 3'b000;
    #1;
    chk("ab_drop_we", write_enb, 8'd0); chk("ab_drop_busy", busy, 8'd0);
    cyc(1'b1, 8'h0D); chk("ab_no_pd", parity_done, 8'd0); chk("ab_err_kept", err, 8'd1);
                      chk("ab_dec_busy", busy, 8'd0);
    cyc(1'b1, 8'h11); chk("ab_next_lfd", lfd_state, 8'd1);

    // Synchronous reset mid-packet
    cyc(1'b1, 8'h11); chk("mr_we_hdr", write_enb, 8'h02);
    reset = 1'b1;
    cyc(1'b0, 8'h00);
    reset = 1'b0;
    #1;
    chk("mr_busy", busy, 8'd0);
    chk("mr_we", write_enb, 8'd0);
    chk("mr_lfd", lfd_state, 8'd0);
    chk("mr_do", data_out, 8'd0);
    chk("mr_err", err, 8'd0);
    chk("mr_pd", parity_done, 8'd0);

    // Backpressure on port 1 after the second payload byte
    cyc(1'b1, 8'h0D); chk("bp_hdr_busy", busy, 8'd0);
    cyc(1'b1, 8'h11); chk("bp_lfd", lfd_state, 8'd1);
    cyc(1'b1, 8'h11); chk("bp_we_hdr", write_enb, 8'h02); chk("bp_do_hdr", data_out, 8'h0D);
    cyc(1'b1, 8'h22); chk("bp_we_p1", write_enb, 8'h02); chk("bp_do_p1", data_out, 8'h11);
    cyc(1'b1, 8'h33);
    fifo_full = 3'b010;
    #1;
    chk("bp_full_busy", busy, 8'd1); chk("bp_full_we", write_enb, 8'd0);
    chk("bp_full_do", data_out, 8'h22);
    cyc(1'b1, 8'h33); chk("bp_wait_busy", busy, 8'd1); chk("bp_wait_we", write_enb, 8'd0);
                      chk("bp_wait_do", data_out, 8'h22);
    cyc(1'b1, 8'h33);
    fifo_full = 3'b000;
    #1;
    chk("bp_rel_we", write_enb, 8'h02); chk("bp_rel_do", data_out, 8'h22);
    cyc(1'b1, 8'h33); chk("bp_resume_busy", busy, 8'd0); chk("bp_resume_we", write_enb, 8'd0);
    cyc(1'b0, 8'h0D); chk("bp_we_p3", write_enb, 8'h02); chk("bp_do_p3", data_out, 8'h33);
    cyc(1'b0, 8'h00); chk("bp_we_par", write_enb, 8'h02); chk("bp_do_par", data_out, 8'h0D);
    cyc(1'b0, 8'h00); chk("bp_chk_busy", busy, 8'd1);
    cyc(1'b0, 8'h00); chk("bp_pd", parity_done, 8'd1); chk("bp_err", err, 8'd0);

    // Busy destination: port 2 not empty when its header arrives
    fifo_empty = 3'b011;
    cyc(1'b1, 8'h06); chk("be_hdr_busy", busy, 8'd0);
    cyc(1'b1, 8'h5A); chk("be_wait_busy", busy, 8'd1); chk("be_wait_lfd", lfd_state, 8'd0);
                      chk("be_wait_we", write_enb, 8'd0);
    cyc(1'b1, 8'h5A); chk("be_wait2_busy", busy, 8'd1); chk("be_wait2_lfd", lfd_state, 8'd0);
    cyc(1'b1, 8'h5A);
    fifo_empty = 3'b111;
    #1;
    chk("be_wait3_lfd", lfd_state, 8'd0); chk("be_wait3_busy", busy, 8'd1);
    cyc(1'b1, 8'h5A); chk("be_lfd", lfd_state, 8'd1); chk("be_lfd_we", write_enb, 8'd0);
    cyc(1'b1, 8'h5A); chk("be_we_hdr", write_enb, 8'h04); chk("be_do_hdr", data_out, 8'h06);
    cyc(1'b0, 8'h5C); chk("be_we_p1", write_enb, 8'h04); chk("be_do_p1", data_out, 8'h5A);
    cyc(1'b0, 8'h00); chk("be_we_par", write_enb, 8'h04); chk("be_do_par", data_out, 8'h5C);
    cyc(1'b0, 8'h00); chk("be_chk_busy", busy, 8'd1);
    cyc(1'b0, 8'h00); chk("be_pd", parity_done, 8'd1); chk("be_err", err, 8'd0);

    // Invalid address, then a zero-length packet with a wrong parity byte
    cyc(1'b1, 8'h0B); chk("ia_hdr_busy", busy, 8'd0); chk("ia_hdr_we", write_enb, 8'd0);
    cyc(1'b1, 8'hAA); chk("ia_p1_busy", busy, 8'd0); chk("ia_p1_we", write_enb, 8'd0);
    cyc(1'b1, 8'hBB); chk("ia_p2_busy", busy, 8'd0); chk("ia_p2_we", write_enb, 8'd0);
    cyc(1'b0, 8'hC0); chk("ia_par_busy", busy, 8'd0); chk("ia_par_we", write_enb, 8'd0);
    cyc(1'b1, 8'h01); chk("ia_dec_busy", busy, 8'd0); chk("ia_dec_pd", parity_done, 8'd0);
    cyc(1'b0, 8'h00); chk("zl_lfd", lfd_state, 8'd1);
    cyc(1'b0, 8'h00); chk("zl_we_hdr", write_enb, 8'h02); chk("zl_do_hdr", data_out, 8'h01);
    cyc(1'b0, 8'h00); chk("zl_we_par", write_enb, 8'h02); chk("zl_do_par", data_out, 8'h00);
                      chk("zl_flush_busy", busy, 8'd1);
    cyc(1'b0, 8'h00); chk("zl_chk_busy", busy, 8'd1);
    cyc(1'b0, 8'h00); chk("zl_pd", parity_done, 8'd1); chk("zl_err", err, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
